// File: rtl/rv_pipe_pkg.sv
// rv_pipe_pkg: shared pipeline constants, ctrl_mem bit positions and MEM-stage state encoding.
package rv_pipe_pkg;
    localparam int XLEN_DEFAULT  = 64;
    localparam int MEM_WRITE_BIT = 0;
    localparam int MEM_READ_BIT  = 1;
    localparam int WB_CTRL_MSB   = 3;
    localparam int WB_CTRL_LSB   = 2;
    typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} mem_state_e;
endpackage

// File: rtl/mem_timeout_counter.sv
// mem_timeout_counter: BUSY-cycle watchdog for mem_stage, terminal count at TIMEOUT_CYCLES-1.
// Only built with MEM_TIMEOUT_EN defined.
`ifdef MEM_TIMEOUT_EN
module mem_timeout_counter #(
    parameter int TIMEOUT_CYCLES = 16,
    localparam int W = $clog2(TIMEOUT_CYCLES)
) (
    input  logic clk,
    input  logic reset_n,
    input  logic clear,
    input  logic enable,
    output logic tc
);
    logic [W-1:0] count_q, count_d;
    always_comb count_d = clear ? '0 : enable ? count_q + 1'b1 : count_q;
    always_ff @(posedge clk or negedge reset_n)
        if (!reset_n) count_q <= '0;
        else count_q <= count_d;
    assign tc = count_q == W'(TIMEOUT_CYCLES - 1);
endmodule
`endif

// File: rtl/mem_stage.sv
// mem_stage: pipeline MEM stage; dmem req/ack access with upstream stall, drives MEM/WB register.
// MEM_TIMEOUT_EN adds a forced-completion watchdog with sticky mem_err.
module mem_stage
    import rv_pipe_pkg::*;
#(
    parameter int XLEN           = XLEN_DEFAULT,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic [3:0]      ctrl_mem,
    input  logic [4:0]      rd_mem,
    input  logic [XLEN-1:0] alu_result,
    input  logic [XLEN-1:0] write_data1,
    output logic            stall,
    output logic            dmem_req,
    output logic            dmem_we,
    output logic [XLEN-1:0] dmem_addr,
    output logic [XLEN-1:0] dmem_wdata,
    input  logic            dmem_ack,
    input  logic [XLEN-1:0] dmem_rdata,
    output logic [1:0]      ctrl_wb,
    output logic [4:0]      rd_wb,
    output logic [XLEN-1:0] read_data,
    output logic [XLEN-1:0] alu_result_wb,
    output logic            mem_err
);
    mem_state_e      state_q, state_d;
    logic [1:0]      ctrl_wb_q, ctrl_wb_d, ctrl_lat_q, ctrl_lat_d;
    logic [4:0]      rd_wb_q, rd_wb_d, rd_lat_q, rd_lat_d;
    logic [XLEN-1:0] read_data_q, read_data_d, alu_wb_q, alu_wb_d, alu_lat_q, alu_lat_d;
    logic [XLEN-1:0] addr_q, addr_d, wdata_q, wdata_d;
    logic            we_q, we_d, err_q, err_d;
    logic            mem_op, busy, timeout, done;

    assign mem_op = ctrl_mem[MEM_WRITE_BIT] | ctrl_mem[MEM_READ_BIT];
    assign busy   = state_q == BUSY;
    assign done   = busy & (dmem_ack | timeout);

`ifdef MEM_TIMEOUT_EN
    logic tc;
    mem_timeout_counter #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timeout (
        .clk    (clk),
        .reset_n(reset_n),
        .clear  (~busy),
        .enable (busy & ~dmem_ack),
        .tc     (tc)
    );
    assign timeout = busy & tc & ~dmem_ack;
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
    assign timeout = 1'b0;
`endif

    // Gated by reset_n so an abandoned access releases upstream immediately.
    assign stall    = reset_n & (busy ? ~done : mem_op);
    assign dmem_req = busy;

    always_comb begin
        state_d     = state_q;
        ctrl_wb_d   = ctrl_wb_q;
        rd_wb_d     = rd_wb_q;
        read_data_d = read_data_q;
        alu_wb_d    = alu_wb_q;
        ctrl_lat_d  = ctrl_lat_q;
        rd_lat_d    = rd_lat_q;
        alu_lat_d   = alu_lat_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        we_d        = we_q;
        err_d       = err_q | timeout;
        if (!busy && mem_op) begin
            addr_d     = alu_result;
            wdata_d    = write_data1;
            we_d       = ctrl_mem[MEM_WRITE_BIT];
            ctrl_lat_d = ctrl_mem[WB_CTRL_MSB:WB_CTRL_LSB];
            rd_lat_d   = rd_mem;
            alu_lat_d  = alu_result;
            ctrl_wb_d  = '0;
            state_d    = BUSY;
        end else if (!busy) begin
            ctrl_wb_d = ctrl_mem[WB_CTRL_MSB:WB_CTRL_LSB];
            rd_wb_d   = rd_mem;
            alu_wb_d  = alu_result;
        end else if (done) begin
            ctrl_wb_d   = ctrl_lat_q;
            rd_wb_d     = rd_lat_q;
            alu_wb_d    = alu_lat_q;
            read_data_d = we_q ? read_data_q : dmem_ack ? dmem_rdata : '0;
            state_d     = IDLE;
        end else begin
            ctrl_wb_d = '0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            ctrl_wb_q   <= '0;
            rd_wb_q     <= '0;
            read_data_q <= '0;
            alu_wb_q    <= '0;
            ctrl_lat_q  <= '0;
            rd_lat_q    <= '0;
            alu_lat_q   <= '0;
            addr_q      <= '0;
            wdata_q     <= '0;
            we_q        <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            ctrl_wb_q   <= ctrl_wb_d;
            rd_wb_q     <= rd_wb_d;
            read_data_q <= read_data_d;
            alu_wb_q    <= alu_wb_d;
            ctrl_lat_q  <= ctrl_lat_d;
            rd_lat_q    <= rd_lat_d;
            alu_lat_q   <= alu_lat_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            we_q        <= we_d;
            err_q       <= err_d;
        end
    end

    assign ctrl_wb       = ctrl_wb_q;
    assign rd_wb         = rd_wb_q;
    assign read_data     = read_data_q;
    assign alu_result_wb = alu_wb_q;
    assign dmem_we       = we_q;
    assign dmem_addr     = addr_q;
    assign dmem_wdata    = wdata_q;
    assign mem_err       = err_q;
endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: directed stimulus for mem_stage with a transaction-level reference model
// checked every cycle, plus hand-computed expectations per scenario.
module tb_mem_stage;
    localparam int XLEN = 64;
    localparam int TO   = 4;
`ifdef MEM_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic            clk = 1'b0, reset_n = 1'b0;
    logic [3:0]      ctrl_mem = '0;
    logic [4:0]      rd_mem = '0;
    logic [XLEN-1:0] alu_result = '0, write_data1 = '0, dmem_rdata = '0;
    logic            dmem_ack = 1'b0;
    logic            stall, dmem_req, dmem_we, mem_err;
    logic [XLEN-1:0] dmem_addr, dmem_wdata, read_data, alu_result_wb;
    logic [1:0]      ctrl_wb;
    logic [4:0]      rd_wb;

    int tests = 0, fails = 0, stall_cnt = 0;

    mem_stage #(.XLEN(XLEN), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .reset_n(reset_n), .ctrl_mem(ctrl_mem), .rd_mem(rd_mem),
        .alu_result(alu_result), .write_data1(write_data1), .stall(stall),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
        .dmem_wdata(dmem_wdata), .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
        .ctrl_wb(ctrl_wb), .rd_wb(rd_wb), .read_data(read_data),
        .alu_result_wb(alu_result_wb), .mem_err(mem_err)
    );

    always #5 clk = ~clk;

    // Reference model: one outstanding access plus the writeback it will produce.
    bit              m_out;
    int              m_wait;
    logic [1:0]      e_ctrl, l_ctrl;
    logic [4:0]      e_rd, l_rd;
    logic [XLEN-1:0] e_rdata, e_alu, l_alu, e_addr, e_wdata;
    logic            e_we, e_err;

    task automatic m_clear();
        m_out = 0; m_wait = 0;
        e_ctrl = '0; l_ctrl = '0; e_rd = '0; l_rd = '0;
        e_rdata = '0; e_alu = '0; l_alu = '0; e_addr = '0; e_wdata = '0;
        e_we = 1'b0; e_err = 1'b0;
    endtask

    function automatic bit m_timeout();
        return TO_EN && m_out && m_wait == TO - 1 && !dmem_ack;
    endfunction

    function automatic bit m_stall();
        if (!reset_n) return 1'b0;
        if (m_out) return !(dmem_ack || m_timeout());
        return ctrl_mem[0] || ctrl_mem[1];
    endfunction

    task automatic m_step();
        bit to;
        to = m_timeout();
        if (!m_out && (ctrl_mem[0] || ctrl_mem[1])) begin
            m_out = 1; m_wait = 0;
            e_we = ctrl_mem[0]; e_addr = alu_result; e_wdata = write_data1;
            l_ctrl = ctrl_mem[3:2]; l_rd = rd_mem; l_alu = alu_result;
            e_ctrl = '0;
        end else if (!m_out) begin
            e_ctrl = ctrl_mem[3:2]; e_rd = rd_mem; e_alu = alu_result;
        end else if (dmem_ack || to) begin
            e_ctrl = l_ctrl; e_rd = l_rd; e_alu = l_alu;
            if (!e_we) e_rdata = dmem_ack ? dmem_rdata : '0;
            if (to) e_err = 1'b1;
            m_out = 0;
        end else begin
            e_ctrl = '0;
            m_wait++;
        end
    endtask

    task automatic chk(input string name, input logic [XLEN-1:0] act, input logic [XLEN-1:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        chk("stall", stall, m_stall());
        chk("dmem_req", dmem_req, m_out);
        chk("dmem_we", dmem_we, e_we);
        chk("dmem_addr", dmem_addr, e_addr);
        chk("dmem_wdata", dmem_wdata, e_wdata);
        chk("ctrl_wb", ctrl_wb, e_ctrl);
        chk("rd_wb", rd_wb, e_rd);
        chk("read_data", read_data, e_rdata);
        chk("alu_result_wb", alu_result_wb, e_alu);
        chk("mem_err", mem_err, e_err);
    end

    task automatic cyc(input logic [3:0] c, input logic [4:0] rd, input logic [XLEN-1:0] alu,
                       input logic [XLEN-1:0] wd, input logic ack, input logic [XLEN-1:0] rdata);
        ctrl_mem = c; rd_mem = rd; alu_result = alu; write_data1 = wd;
        dmem_ack = ack; dmem_rdata = rdata;
        #2;
        if (stall) stall_cnt++;
        @(posedge clk);
        if (reset_n) m_step();
        #1;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        m_clear();
        #1;
        chk("rst_stall", stall, 0);
        chk("rst_req", dmem_req, 0);
        chk("rst_read_data", read_data, 0);
        cyc(4'b1110, 5'd3, 64'h40, 64'h0, 1'b0, 64'h0);
        cyc(4'b1110, 5'd3, 64'h40, 64'h0, 1'b0, 64'h0);
        reset_n = 1'b1;
    endtask

    initial begin
        m_clear();
        @(posedge clk); #1;
        do_reset();
        chk("reset_ctrl_wb", ctrl_wb, 0);
        chk("reset_mem_err", mem_err, 0);

        stall_cnt = 0;
        cyc(4'b0100, 5'd5, 64'h2A, 64'h0, 1'b0, 64'h0);
        chk("alu_ctrl_wb", ctrl_wb, 2'b01);
        chk("alu_rd_wb", rd_wb, 5'd5);
        chk("alu_result_wb", alu_result_wb, 64'h2A);
        chk("alu_no_stall", stall_cnt, 0);

        stall_cnt = 0;
        cyc(4'b1110, 5'd9, 64'h100, 64'h0, 1'b0, 64'h0);
        chk("ld_req", dmem_req, 1);
        chk("ld_bubble1", ctrl_wb, 0);
        chk("ld_addr", dmem_addr, 64'h100);
        cyc(4'b1110, 5'd9, 64'h100, 64'h0, 1'b0, 64'h0);
        chk("ld_bubble2", ctrl_wb, 0);
        cyc(4'b1110, 5'd9, 64'h100, 64'h0, 1'b0, 64'h0);
        chk("ld_bubble3", ctrl_wb, 0);
        cyc(4'b1110, 5'd9, 64'h100, 64'h0, 1'b1, 64'hDEAD);
        chk("ld_ctrl_wb", ctrl_wb, 2'b11);
        chk("ld_read_data", read_data, 64'hDEAD);
        chk("ld_rd_wb", rd_wb, 5'd9);
        chk("ld_stall_cycles", stall_cnt, 3);
        chk("ld_req_drop", dmem_req, 0);

        stall_cnt = 0;
        cyc(4'b0001, 5'd0, 64'h80, 64'h55, 1'b1, 64'h0);
        chk("st_we", dmem_we, 1);
        chk("st_addr", dmem_addr, 64'h80);
        chk("st_wdata", dmem_wdata, 64'h55);
        cyc(4'b0001, 5'd0, 64'h80, 64'h55, 1'b1, 64'hBAD);
        chk("st_read_data_kept", read_data, 64'hDEAD);
        chk("st_ctrl_wb", ctrl_wb, 0);
        chk("st_stall_cycles", stall_cnt, 1);

        cyc(4'b1110, 5'd4, 64'h200, 64'h0, 1'b0, 64'h0);
        cyc(4'b1110, 5'd4, 64'h200, 64'h0, 1'b1, 64'hBEEF);
        chk("b2b_ld_ctrl", ctrl_wb, 2'b11);
        chk("b2b_ld_data", read_data, 64'hBEEF);
        cyc(4'b0100, 5'd7, 64'h33, 64'h0, 1'b0, 64'h0);
        chk("b2b_alu_ctrl", ctrl_wb, 2'b01);
        chk("b2b_alu_rd", rd_wb, 5'd7);
        chk("b2b_alu_val", alu_result_wb, 64'h33);

        cyc(4'b1110, 5'd2, 64'h300, 64'h0, 1'b0, 64'h0);
        cyc(4'b1110, 5'd2, 64'h300, 64'h0, 1'b0, 64'h0);
        chk("mid_req_before", dmem_req, 1);
        do_reset();
        cyc(4'b1110, 5'd6, 64'h400, 64'h0, 1'b0, 64'h0);
        cyc(4'b1110, 5'd6, 64'h400, 64'h0, 1'b1, 64'h77);
        chk("post_rst_data", read_data, 64'h77);
        chk("post_rst_rd", rd_wb, 5'd6);

`ifdef MEM_TIMEOUT_EN
        stall_cnt = 0;
        for (int i = 0; i < 5; i++) cyc(4'b1110, 5'd8, 64'h500, 64'h0, 1'b0, 64'hFFFF);
        chk("to_stall_cycles", stall_cnt, 4);
        chk("to_read_data", read_data, 0);
        chk("to_mem_err", mem_err, 1);
        chk("to_ctrl_wb", ctrl_wb, 2'b11);
        cyc(4'b0100, 5'd1, 64'h1, 64'h0, 1'b0, 64'h0);
        chk("to_err_sticky", mem_err, 1);
        do_reset();
        for (int i = 0; i < 4; i++) cyc(4'b1110, 5'd8, 64'h600, 64'h0, 1'b0, 64'h0);
        cyc(4'b1110, 5'd8, 64'h600, 64'h0, 1'b1, 64'h1234);
        chk("to_ack_data", read_data, 64'h1234);
        chk("to_ack_no_err", mem_err, 0);
`endif

        cyc(4'b0000, 5'd0, 64'h0, 64'h0, 1'b0, 64'h0);
        @(negedge clk); #1;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
